fetch_unit: RTL and testbench

- Instruction fetch stage plus IF/ID pipeline register; sits directly upstream of the decode stage and its ID/EX latch.
- Owns the PC and drives the instruction-cache request handshake (iREN/iaddr/ihit).
- Absorbs decode stalls with a one-entry skid buffer; applies branch/jump redirects from execute, including redirects that arrive while a cache miss is outstanding.
- Presents instruction, pc_plus_4 and valid to decode.

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/fetch_latch_if.sv | 13 +
 rtl/fetch_skid_buf.sv | 34 +++
 rtl/fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_fetch_unit.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch stage and its neighbours.
// Word type, fetch FSM states and the bubble instruction encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } fetch_state_t;

    localparam word_t NOP = 32'h0000_0000;

endpackage

// File: rtl/fetch_latch_if.sv
// IF/ID latch bundle seen by the decode stage.
// Fetch drives it, decode only reads it.
interface fetch_latch_if;
    import cpu_types_pkg::*;

    word_t instr;
    word_t pc_plus_4;
    logic  valid;

    modport fetch  (output instr, pc_plus_4, valid);
    modport decode (input  instr, pc_plus_4, valid);

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid register holding a fetched instruction
// that decode could not take yet.
module fetch_skid_buf
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  load,
    input  logic  pop,
    input  logic  clear,
    input  word_t din_instr,
    input  word_t din_pc4,
    output logic  valid,
    output word_t instr,
    output word_t pc_plus_4
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid     <= 1'b0;
            instr     <= '0;
            pc_plus_4 <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid     <= 1'b1;
            instr     <= din_instr;
            pc_plus_4 <= din_pc4;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID register, skid buffer and
// redirect/halt handling across outstanding cache misses.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT   = 32'h0000_0000,
    parameter word_t NOP_INSTR = NOP
) (
    input  logic  CLK,
    input  logic  nRST,
    output logic  iREN,
    output word_t iaddr,
    input  logic  ihit,
    input  word_t iload,
    input  logic  stall,
    input  logic  redirect,
    input  word_t redirect_pc,
    input  logic  halt,
    output word_t instr_out,
    output word_t pc_plus_4_out,
    output logic  valid_out
);

    fetch_state_t state, state_n;
    word_t        pc_q, pc_n;
    word_t        redir_q, redir_n;
    logic         halt_pend, hp_n;

    logic  hold_valid;
    word_t hold_instr, hold_pc4;
    logic  sk_ld, sk_pop, sk_clr;

    logic  lat_ld;
    word_t lat_instr, lat_pc4;
    logic  lat_v;

    logic  hit, miss;
    word_t pc_inc;

    fetch_latch_if lat ();

    assign iREN   = (state == DRAIN) | ((state == RUN) & ~hold_valid);
    assign iaddr  = pc_q;
    assign hit    = iREN & ihit;
    assign miss   = iREN & ~ihit;
    assign pc_inc = pc_q + 32'd4;

    assign instr_out     = lat.instr;
    assign pc_plus_4_out = lat.pc_plus_4;
    assign valid_out     = lat.valid;

    fetch_skid_buf u_skid (
        .CLK       (CLK),
        .nRST      (nRST),
        .load      (sk_ld),
        .pop       (sk_pop),
        .clear     (sk_clr),
        .din_instr (iload),
        .din_pc4   (pc_inc),
        .valid     (hold_valid),
        .instr     (hold_instr),
        .pc_plus_4 (hold_pc4)
    );

    // Latch controls default to loading a bubble when lat_ld is set.
    always_comb begin
        state_n   = state;
        pc_n      = pc_q;
        redir_n   = redir_q;
        hp_n      = halt_pend;
        lat_ld    = 1'b0;
        lat_instr = NOP_INSTR;
        lat_pc4   = '0;
        lat_v     = 1'b0;
        sk_ld     = 1'b0;
        sk_pop    = 1'b0;
        sk_clr    = 1'b0;
        case (state)
            RUN: begin
                if (halt) begin
                    lat_ld = 1'b1;
                    sk_clr = 1'b1;
                    if (miss) begin
                        state_n = DRAIN;
                        hp_n    = 1'b1;
                    end else begin
                        state_n = HALTED;
                    end
                end else if (redirect) begin
                    lat_ld = 1'b1;
                    sk_clr = 1'b1;
                    if (miss) begin
                        redir_n = redirect_pc;
                        state_n = DRAIN;
                    end else begin
                        pc_n = redirect_pc;
                    end
                end else if (hold_valid && !stall) begin
                    lat_ld    = 1'b1;
                    lat_instr = hold_instr;
                    lat_pc4   = hold_pc4;
                    lat_v     = 1'b1;
                    sk_pop    = 1'b1;
                end else if (hit && !stall) begin
                    lat_ld    = 1'b1;
                    lat_instr = iload;
                    lat_pc4   = pc_inc;
                    lat_v     = 1'b1;
                    pc_n      = pc_inc;
                end else if (hit) begin
                    sk_ld = 1'b1;
                    pc_n  = pc_inc;
                end else if (!stall) begin
                    lat_ld = 1'b1;
                end
            end
            DRAIN: begin
                lat_ld = ~stall;
                // A redirect or halt arriving with the hit still counts.
                if (redirect) redir_n = redirect_pc;
                if (halt) hp_n = 1'b1;
                if (ihit) begin
                    if (hp_n) begin
                        state_n = HALTED;
                    end else begin
                        pc_n    = redir_n;
                        state_n = RUN;
                    end
                end
            end
            default: begin
                lat_ld = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= RUN;
            pc_q      <= PC_INIT;
            redir_q   <= '0;
            halt_pend <= 1'b0;
        end else begin
            state     <= state_n;
            pc_q      <= pc_n;
            redir_q   <= redir_n;
            halt_pend <= hp_n;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lat.instr     <= NOP_INSTR;
            lat.pc_plus_4 <= '0;
            lat.valid     <= 1'b0;
        end else if (lat_ld) begin
            lat.instr     <= lat_instr;
            lat.pc_plus_4 <= lat_pc4;
            lat.valid     <= lat_v;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, corner sequences,
// then random traffic checked against a queue-based model.
module tb_fetch_unit;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  nRST;
    logic  iREN;
    word_t iaddr;
    logic  ihit;
    word_t iload;
    logic  stall;
    logic  redirect;
    word_t redirect_pc;
    logic  halt;
    word_t instr_out;
    word_t pc_plus_4_out;
    logic  valid_out;

    always #5 CLK = ~CLK;

    fetch_unit #(
        .PC_INIT   (32'h0),
        .NOP_INSTR (32'h0)
    ) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .iREN          (iREN),
        .iaddr         (iaddr),
        .ihit          (ihit),
        .iload         (iload),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .halt          (halt),
        .instr_out     (instr_out),
        .pc_plus_4_out (pc_plus_4_out),
        .valid_out     (valid_out)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic obs(input string tag, input logic e_iren,
                       input word_t e_addr, input word_t e_ins,
                       input word_t e_p4, input logic e_v);
        chk({tag, ".iREN"}, {31'd0, iREN}, {31'd0, e_iren});
        chk({tag, ".iaddr"}, iaddr, e_addr);
        chk({tag, ".instr"}, instr_out, e_ins);
        chk({tag, ".pc4"}, pc_plus_4_out, e_p4);
        chk({tag, ".valid"}, {31'd0, valid_out}, {31'd0, e_v});
    endtask

    task automatic drive(input logic st, input logic rd, input word_t rpc,
                         input logic hl, input logic hit, input word_t ld);
        @(negedge CLK);
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        halt        = hl;
        ihit        = hit;
        iload       = ld;
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        {stall, redirect, halt, ihit} = '0;
        redirect_pc = '0;
        iload       = '0;
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    // Reference model: skid buffer as a queue, modes as bench-local names.
    typedef enum {M_RUN, M_DRAIN, M_HALT} mmode_t;
    mmode_t      m_mode;
    word_t       m_pc, m_tgt;
    bit          m_hp;
    logic [63:0] m_skid[$];
    word_t       m_ins, m_p4;
    logic        m_v;

    task automatic m_reset();
        m_mode = M_RUN;
        m_pc   = 32'h0;
        m_tgt  = 32'h0;
        m_hp   = 0;
        m_skid.delete();
        m_ins  = 32'h0;
        m_p4   = 32'h0;
        m_v    = 1'b0;
    endtask

    function automatic logic m_iren();
        return (m_mode == M_DRAIN) ||
               (m_mode == M_RUN && m_skid.size() == 0);
    endfunction

    task automatic m_bubble();
        m_ins = 32'h0;
        m_p4  = 32'h0;
        m_v   = 1'b0;
    endtask

    task automatic m_step(input logic st, input logic rd, input word_t rpc,
                          input logic hl, input logic ih, input word_t ld);
        logic        req;
        logic        got;
        logic [63:0] e;
        req = m_iren();
        got = req && ih;
        if (m_mode == M_RUN) begin
            if (hl) begin
                m_bubble();
                m_skid.delete();
                if (req && !got) begin
                    m_mode = M_DRAIN;
                    m_hp   = 1;
                end else begin
                    m_mode = M_HALT;
                end
            end else if (rd) begin
                m_bubble();
                m_skid.delete();
                if (req && !got) begin
                    m_tgt  = rpc;
                    m_mode = M_DRAIN;
                end else begin
                    m_pc = rpc;
                end
            end else if (m_skid.size() != 0 && !st) begin
                e     = m_skid.pop_front();
                m_ins = e[63:32];
                m_p4  = e[31:0];
                m_v   = 1'b1;
            end else if (got && !st) begin
                m_ins = ld;
                m_p4  = m_pc + 4;
                m_v   = 1'b1;
                m_pc  = m_pc + 4;
            end else if (got) begin
                m_skid.push_back({ld, m_pc + 32'd4});
                m_pc = m_pc + 4;
            end else if (!st) begin
                m_bubble();
            end
        end else if (m_mode == M_DRAIN) begin
            if (!st) m_bubble();
            if (rd) m_tgt = rpc;
            if (hl) m_hp = 1;
            if (got) begin
                if (m_hp) begin
                    m_mode = M_HALT;
                end else begin
                    m_pc   = m_tgt;
                    m_mode = M_RUN;
                end
            end
        end else begin
            m_bubble();
        end
    endtask

    typedef struct {
        logic  st;
        logic  rd;
        word_t rpc;
        logic  hl;
        logic  hit;
        word_t ld;
        logic  e_iren;
        word_t e_addr;
        word_t e_ins;
        word_t e_p4;
        logic  e_v;
    } vec_t;

    vec_t tbl[18];

    localparam word_t A1 = 32'h2001_0001;
    localparam word_t A2 = 32'h2002_0002;
    localparam word_t A3 = 32'h2003_0003;
    localparam word_t A4 = 32'h2004_0004;
    localparam word_t A5 = 32'h2005_0005;
    localparam word_t A6 = 32'h2006_0006;
    localparam word_t DD = 32'hDEAD_BEEF;

    initial begin
        logic  st, rd, hl, ih;
        word_t rpc, ld;

        // Outputs in each row are those seen before that row's edge.
        tbl[0]  = '{0, 0, 0, 0, 1, A1, 1, 32'h0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 1, A2, 1, 32'h4, A1, 32'h4, 1};
        tbl[2]  = '{1, 0, 0, 0, 1, A3, 1, 32'h8, A2, 32'h8, 1};
        tbl[3]  = '{1, 0, 0, 0, 0, 0, 0, 32'hC, A2, 32'h8, 1};
        tbl[4]  = '{1, 0, 0, 0, 0, 0, 0, 32'hC, A2, 32'h8, 1};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 32'hC, A2, 32'h8, 1};
        tbl[6]  = '{0, 0, 0, 0, 1, A4, 1, 32'hC, A3, 32'hC, 1};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 1, 32'h10, A4, 32'h10, 1};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 1, 32'h10, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 1, 32'h10, 0, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 1, 32'h10, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 1, A5, 1, 32'h10, 0, 0, 0};
        tbl[12] = '{0, 1, 32'h100, 0, 0, 0, 1, 32'h14, A5, 32'h14, 1};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 1, 32'h14, 0, 0, 0};
        tbl[14] = '{0, 1, 32'h200, 0, 0, 0, 1, 32'h14, 0, 0, 0};
        tbl[15] = '{0, 0, 0, 0, 1, DD, 1, 32'h14, 0, 0, 0};
        tbl[16] = '{0, 0, 0, 0, 1, A6, 1, 32'h200, 0, 0, 0};
        tbl[17] = '{0, 0, 0, 0, 0, 0, 1, 32'h204, A6, 32'h204, 1};

        nRST = 1'b0;
        {stall, redirect, halt, ihit} = '0;
        redirect_pc = '0;
        iload       = '0;
        #12;
        obs("reset", 1, 32'h0, 32'h0, 32'h0, 0);
        @(negedge CLK);
        nRST = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].st, tbl[i].rd, tbl[i].rpc, tbl[i].hl,
                  tbl[i].hit, tbl[i].ld);
            obs($sformatf("tbl%0d", i), tbl[i].e_iren, tbl[i].e_addr,
                tbl[i].e_ins, tbl[i].e_p4, tbl[i].e_v);
        end

        // Redirect while stalled with a held entry flushes everything.
        do_reset();
        drive(0, 0, 0, 0, 1, 32'hB1);
        drive(1, 0, 0, 0, 1, 32'hB2);
        drive(1, 1, 32'h300, 0, 0, 0);
        obs("flush.pre", 0, 32'h8, 32'hB1, 32'h4, 1);
        drive(1, 0, 0, 0, 0, 0);
        obs("flush.post", 1, 32'h300, 32'h0, 32'h0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        obs("flush.nohold", 1, 32'h300, 32'h0, 32'h0, 0);

        // PC wrap at the top of the address space.
        do_reset();
        drive(0, 1, 32'hFFFF_FFFC, 0, 1, DD);
        drive(0, 0, 0, 0, 1, 32'hC1);
        obs("wrap.fetch", 1, 32'hFFFF_FFFC, 32'h0, 32'h0, 0);
        drive(0, 0, 0, 0, 0, 0);
        obs("wrap.out", 1, 32'h0, 32'hC1, 32'h0, 1);

        // Halt during a miss drains, then halts; reset releases it.
        do_reset();
        drive(0, 0, 0, 0, 1, A1);
        drive(0, 0, 0, 1, 0, 0);
        obs("halt.req", 1, 32'h4, A1, 32'h4, 1);
        drive(0, 0, 0, 0, 0, 0);
        obs("halt.drain", 1, 32'h4, 32'h0, 32'h0, 0);
        drive(0, 1, 32'h40, 0, 1, DD);
        obs("halt.hit", 1, 32'h4, 32'h0, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(i[0], 1, 32'h80, 0, 0, 0);
            obs($sformatf("halted%0d", i), 0, 32'h4, 32'h0, 32'h0, 0);
        end
        #2;
        nRST = 1'b0;
        #1;
        obs("halt.reset", 1, 32'h0, 32'h0, 32'h0, 0);
        @(negedge CLK);
        nRST = 1'b1;

        // Random traffic against the reference model.
        do_reset();
        m_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(299) == 0) begin
                do_reset();
                m_reset();
            end
            st  = ($urandom_range(99) < 30);
            rd  = ($urandom_range(99) < 8);
            rpc = {$urandom_range(32'h3FFF), 2'b00};
            hl  = ($urandom_range(99) < 1);
            ih  = m_iren() && ($urandom_range(99) < 60);
            ld  = $urandom;
            drive(st, rd, rpc, hl, ih, ld);
            obs("rand", m_iren(), m_pc, m_ins, m_p4, m_v);
            m_step(st, rd, rpc, hl, ih, ld);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
